// File: rtl/cpu_pkg.sv
// Shared types and instruction field layout for the multi-cycle
// fetch/decode/execute sequencer.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_PAUSED,
    S_HALTED
  } state_e;

  // opcode sits in the top nibble, operands in the next two
  localparam int OPC_W   = 4;
  localparam int OPR_W   = 4;
  localparam int OP1_LSB = 8;
  localparam int OP2_LSB = 4;

  localparam logic [OPC_W-1:0] HALT_OP_C = 4'hF;

endpackage

// File: rtl/cpu_sequencer_pc_counter.sv
// Program counter: synchronous clear to zero, increment with silent
// wrap at 2^W-1.
module pc_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] pc_o
);

  logic [W-1:0] pc_q;
  logic [W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (clr_i) begin
      pc_d = '0;
    end else if (inc_i) begin
      pc_d = pc_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXECUTE/WRITEBACK walk,
// imem req/ack handshake, instruction register, run/step/halt control.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int               PC_W    = 8,
  parameter int               INSTR_W = 16,
  parameter int               RES_W   = 8,
  parameter logic [OPC_W-1:0] HALT_OP = HALT_OP_C
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               step_mode,
  input  logic               step,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  input  logic [RES_W-1:0]   exe_result,
  output logic [RES_W-1:0]   result,
  output logic               result_valid,
  output logic [PC_W-1:0]    pc,
  output logic [15:0]        retired,
  output logic               busy,
  output logic               halted
);

  state_e               state_q;
  logic [INSTR_W-1:0]   instr_q;
  logic [RES_W-1:0]     result_q;
  logic [15:0]          retired_q;
  logic                 req_q;
  logic                 rv_q;
  logic                 busy_q;
  logic                 halted_q;
  logic [PC_W-1:0]      pc_w;
  logic                 pc_clr;
  logic                 pc_inc;
  logic                 launch;
  logic [OPC_W-1:0]     opcode;

  assign opcode = instr_q[INSTR_W-1 -: OPC_W];
  assign launch = start &&
                  (state_q == S_IDLE || state_q == S_HALTED);
  assign pc_clr = launch;
  assign pc_inc = (state_q == S_WRITEBACK);

  pc_counter #(
    .W(PC_W)
  ) u_pc (
    .clk  (clk),
    .rst  (rst),
    .clr_i(pc_clr),
    .inc_i(pc_inc),
    .pc_o (pc_w)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      instr_q   <= '0;
      result_q  <= '0;
      retired_q <= '0;
      req_q     <= 1'b0;
      rv_q      <= 1'b0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      rv_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_HALTED: begin
          if (launch) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
            req_q     <= 1'b1;
            busy_q    <= 1'b1;
            halted_q  <= 1'b0;
          end
        end
        S_FETCH: begin
          if (imem_ack) begin
            instr_q <= imem_rdata;
            req_q   <= 1'b0;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (opcode == HALT_OP) begin
            state_q  <= S_HALTED;
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
          end else begin
            state_q <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          state_q <= S_WRITEBACK;
          rv_q    <= 1'b1;
        end
        S_WRITEBACK: begin
          result_q <= exe_result;
          if (retired_q != 16'hFFFF) begin
            retired_q <= retired_q + 16'd1;
          end
          // a step pulse landing here releases the next fetch at once
          if (step_mode && !step) begin
            state_q <= S_PAUSED;
          end else begin
            state_q <= S_FETCH;
            req_q   <= 1'b1;
          end
        end
        S_PAUSED: begin
          if (step || !step_mode) begin
            state_q <= S_FETCH;
            req_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign imem_req     = req_q;
  assign imem_addr    = pc_w;
  assign instr        = instr_q;
  assign result       = result_q;
  assign result_valid = rv_q;
  assign pc           = pc_w;
  assign retired      = retired_q;
  assign busy         = busy_q;
  assign halted       = halted_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: instruction-level reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_cpu_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        step_mode;
  logic        step;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] instr;
  logic [7:0]  exe_result;
  logic [7:0]  result;
  logic        result_valid;
  logic [7:0]  pc;
  logic [15:0] retired;
  logic        busy;
  logic        halted;

  cpu_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .step_mode   (step_mode),
    .step        (step),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .exe_result  (exe_result),
    .result      (result),
    .result_valid(result_valid),
    .pc          (pc),
    .retired     (retired),
    .busy        (busy),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stand-in execute stage: fixed value or the operand byte
  logic exe_fixed;
  assign exe_result = exe_fixed ? 8'h05 : instr[11:4];

  int n_chk;
  int n_fail;
  int cyc;
  bit chk_en;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // instruction memory with per-address wait states
  logic [15:0] mem [256];
  int          dly [256];
  int          waited;
  int          req0;
  int          ack0_cyc;

  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 16'hF0F0;
    waited     = 0;
    forever begin
      @(negedge clk);
      if (imem_req) begin
        if (imem_addr == 8'd0) req0++;
        if (waited == dly[imem_addr]) begin
          imem_ack   = 1'b1;
          imem_rdata = mem[imem_addr];
          waited     = 0;
          if (imem_addr == 8'd0) ack0_cyc = cyc;
        end else begin
          imem_ack   = 1'b0;
          imem_rdata = 16'hF0F0;
          waited++;
        end
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 16'hF0F0;
        waited     = 0;
      end
    end
  end

  // reference: mode 0 idle, 1 fetch, 2 in flight (k cycles since ack),
  // 3 paused, 4 halted
  int          m_mode;
  int          m_k;
  logic [7:0]  m_pc;
  logic [7:0]  m_res;
  logic [15:0] m_ret;
  logic [15:0] m_instr;

  initial begin
    m_mode = 0; m_k = 0; m_pc = 0;
    m_res = 0; m_ret = 0; m_instr = 0;
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_mode = 0; m_pc = 0; m_res = 0;
        m_ret = 0; m_instr = 0;
      end else begin
        case (m_mode)
          0, 4: if (start) begin
            m_mode = 1; m_pc = 0; m_ret = 0;
          end
          1: if (imem_ack) begin
            m_instr = imem_rdata; m_mode = 2; m_k = 1;
          end
          2: begin
            if (m_k == 1 && m_instr[15:12] == 4'hF) begin
              m_mode = 4;
            end else if (m_k < 3) begin
              m_k++;
            end else begin
              m_res = exe_fixed ? 8'h05 : m_instr[11:4];
              m_pc  = m_pc + 8'd1;
              if (m_ret != 16'hFFFF) m_ret = m_ret + 16'd1;
              m_mode = (step_mode && !step) ? 3 : 1;
            end
          end
          3: if (step || !step_mode) m_mode = 1;
          default: m_mode = 0;
        endcase
      end
    end
  end

  int rv_q[$];

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("imem_req", 32'(imem_req), 32'(m_mode == 1));
        if (imem_req) chk("imem_addr", 32'(imem_addr), 32'(m_pc));
        chk("instr", 32'(instr), 32'(m_instr));
        chk("result", 32'(result), 32'(m_res));
        chk("result_valid", 32'(result_valid),
            32'(m_mode == 2 && m_k == 3));
        chk("pc", 32'(pc), 32'(m_pc));
        chk("retired", 32'(retired), 32'(m_ret));
        chk("busy", 32'(busy),
            32'(m_mode == 1 || m_mode == 2 || m_mode == 3));
        chk("halted", 32'(halted), 32'(m_mode == 4));
        if (result_valid) rv_q.push_back(cyc);
      end
    end
  end

  task automatic pulse_start(output int s);
    @(negedge clk);
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halt(input string nm, input int budget);
    int i;
    i = 0;
    while (!halted && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk({nm, "_halt_reached"}, 32'(halted), 32'd1);
  endtask

  int s;
  int p;

  initial begin
    rst = 1'b1; start = 1'b0; step = 1'b0; step_mode = 1'b0;
    exe_fixed = 1'b1; chk_en = 1'b0;
    n_chk = 0; n_fail = 0; req0 = 0; ack0_cyc = -1;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'hF000; dly[i] = 0;
    end

    // reset state
    @(negedge clk); @(negedge clk);
    chk_en = 1'b1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    rst = 1'b0;

    // plain run, fixed exe_result, halts on the third word
    mem[0] = 16'h1230; mem[1] = 16'h2450; mem[2] = 16'hF000;
    rv_q.delete();
    pulse_start(s);
    wait_halt("run", 60);
    chk("run_rv_count", 32'(rv_q.size()), 32'd2);
    if (rv_q.size() == 2) begin
      chk("run_rv0_cycle", 32'(rv_q[0]), 32'(s + 4));
      chk("run_rv_spacing", 32'(rv_q[1] - rv_q[0]), 32'd4);
    end
    chk("run_retired", 32'(retired), 32'd2);
    chk("run_pc", 32'(pc), 32'd2);
    chk("run_result", 32'(result), 32'h05);

    // restart from HALTED with three wait states on address 0
    exe_fixed = 1'b0;
    dly[0] = 3;
    rv_q.delete();
    req0 = 0;
    @(negedge clk);
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
    chk("restart_halted", 32'(halted), 32'd0);
    chk("restart_pc", 32'(pc), 32'd0);
    chk("restart_retired", 32'(retired), 32'd0);
    chk("restart_req", 32'(imem_req), 32'd1);
    @(negedge clk); @(negedge clk);
    chk("wait_instr_held", 32'(instr), 32'hF000);
    wait_halt("wait", 80);
    chk("wait_req_cycles", 32'(req0), 32'd4);
    chk("wait_ack_cycle", 32'(ack0_cyc), 32'(s + 4));
    if (rv_q.size() >= 1)
      chk("wait_rv_after_ack", 32'(rv_q[0] - ack0_cyc), 32'd3);
    chk("wait_result", 32'(result), 32'h45);
    dly[0] = 0;

    // single step
    mem[0] = 16'h1110; mem[1] = 16'h1220;
    mem[2] = 16'h1330; mem[3] = 16'hF000;
    dly[1] = 3;
    step_mode = 1'b1;
    pulse_start(s);
    repeat (8) @(negedge clk);
    chk("step_pause_pc", 32'(pc), 32'd1);
    chk("step_pause_ret", 32'(retired), 32'd1);
    chk("step_pause_busy", 32'(busy), 32'd1);
    chk("step_pause_result", 32'(result), 32'h11);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (12) @(negedge clk);
    chk("step_one_pc", 32'(pc), 32'd2);
    chk("step_one_ret", 32'(retired), 32'd2);
    chk("step_one_req", 32'(imem_req), 32'd0);
    step_mode = 1'b0;
    wait_halt("step", 40);
    chk("step_final_ret", 32'(retired), 32'd3);
    chk("step_final_pc", 32'(pc), 32'd3);
    chk("step_final_result", 32'(result), 32'h33);
    dly[1] = 0;

    // pc wrap over 256 non-halt instructions
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000;
    pulse_start(s);
    p = 0;
    while (retired != 16'd256 && p < 1200) begin
      @(negedge clk);
      p++;
    end
    chk("wrap_retired", 32'(retired), 32'd256);
    chk("wrap_pc", 32'(pc), 32'd0);

    // start while busy is ignored
    repeat (10) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("busy_start_pc_kept", 32'(pc != 8'd0), 32'd1);
    chk("busy_start_ret_kept", 32'(retired > 16'd256), 32'd1);

    // reset while a fetch is outstanding
    p = 0;
    while (!imem_req && p < 10) begin
      @(negedge clk);
      p++;
    end
    chk("midfetch_req_seen", 32'(imem_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midfetch_req", 32'(imem_req), 32'd0);
    chk("midfetch_busy", 32'(busy), 32'd0);
    chk("midfetch_pc", 32'(pc), 32'd0);
    chk("midfetch_instr", 32'(instr), 32'd0);
    chk("midfetch_ret", 32'(retired), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
